cu_stack: RTL and testbench
===========================

Name: cu_stack

Overview:
- Parametrised next-generation SAP control unit: a Moore FSM that decodes the IR opcode and drives register write-enables, ALU op and bus-source selects.
- Over the current CU it adds:
  - a memory wait-state handshake (mem_req/mem_ready);
  - four-flag conditional jumps in both polarities;
  - CALL/RET with an internal, bounds-checked stack pointer that drives the shared bus;
  - a sticky fault state.
- Sits between IR/flag register and the datapath, in place of the current CU.

Parameters:
- OPCODE_W, 8, opcode width; opcode values below are zero-extended to this width.
- ADDR_W, 16, stack-pointer/address width.
- STACK_TOP, 16'hFFFF, SP reset value; the stack grows downward.
- STACK_DEPTH, 16, maximum outstanding CALLs (1..2**ADDR_W-1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  IR opcode field.
- flag  in  4  {V,N,C,Z}; flag[0]=Z, [1]=C, [2]=N, [3]=V.
- mem_ready  in  1  RAM completes the current access this cycle.
- cs  out  14  {acc_write, acc_lower_write, alu_op[3:0], b_write, flag_write, ir_write, mar_write, out_write, pc_inc, pc_write, ram_write}.
- bus_cs  out  6  {sp_to_bus, acc_to_bus, alu_to_bus, ir_to_bus, pc_to_bus, ram_to_bus}; one-hot or zero.
- sp_addr  out  ADDR_W  current SP; valid on the bus when sp_to_bus=1.
- mem_req  out  1  a RAM access is in progress.
- halted  out  1  FSM is in HLT.
- fault  out  1  FSM is in FAULT (stack overflow or underflow).

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset, including mid-wait or mid-CALL, gives at the next edge:
  - state=IDLE, SP=STACK_TOP, depth=0;
  - all cs/bus_cs/mem_req/halted/fault = 0 at the outputs.
- All outputs are combinational from state, opcode and mem_ready only; no flag-dependent outputs.
- Opcodes 0..16 keep the existing encodings (LDA, STA, ADD, SUB, INCA, DECR, JMPZ, JMPC, JMP, NOP, LDI, OUT, HLT, AND, OR, XOR, NOT) and the existing ALU op codes 0..7.
- New opcodes: 17 JMPN, 18 JMPV, 19 JMPNZ, 20 JMPNC, 21 CALL, 22 RET. Any undefined opcode behaves as NOP.
- States: IDLE, F1, F2, LDA1, LDA2, STA1, STA2, ALU1, ALU2, ALU3, JMP1, LDI1, OUT1, CALL1..CALL4, RET1, RET2, HLT, FAULT.
- Existing sequences are unchanged: IDLE->F1->F2->(decode)->...->F1.
- Conditional jumps decide in F2:
  - taken -> JMP1 (ir_to_bus + pc_write);
  - not taken -> F1.
- Memory states are F2, LDA2, STA2, ALU2, CALL3 and RET2. In these states:
  - mem_req=1 and the bus select is held every cycle;
  - the register strobes (ir_write, pc_inc, acc_write, b_write, ram_write, pc_write) assert only in the cycle mem_ready=1;
  - the state holds while mem_ready=0, so wait states are unbounded;
  - with mem_ready tied 1, every instruction takes exactly the current cycle count.
- CALL:
  - decided in F2: depth==STACK_DEPTH -> FAULT; else CALL1.
  - CALL1: internal SP<=SP-1, depth+1; no outputs.
  - CALL2: sp_to_bus, mar_write.
  - CALL3: pc_to_bus, ram_write on ready. PC already points past the CALL.
  - CALL4: ir_to_bus, pc_write -> F1.
  - Total with no waits: 2 fetch + 4 cycles.
- RET:
  - decided in F2: depth==0 -> FAULT; else RET1.
  - RET1: sp_to_bus, mar_write.
  - RET2: ram_to_bus, pc_write on ready; in that same cycle SP<=SP+1, depth-1 -> F1.
- SP arithmetic is modulo 2**ADDR_W. Depth is tracked separately, so wrap of SP alone never faults.
- HLT and FAULT are absorbing with all strobes 0. Only rst exits them.
- halted=1 only in HLT; fault=1 only in FAULT.
- pc_inc and every write strobe are single-cycle per instruction regardless of wait states.

Test Plan:
- Reset/basic: rst 3 cycles, mem_ready=1, then LDA, ADD, OUT, HLT.
  - Required: cs/bus_cs match the existing CU cycle-for-cycle.
  - Required: halted=1 on cycle 2+4+5+3+2 after IDLE, then held.
- Wait states: LDA with mem_ready low 3 cycles in F2 and 2 cycles in LDA2.
  - Required: ram_to_bus and mem_req held.
  - Required: ir_write, pc_inc and acc_write each exactly one pulse, coincident with mem_ready.
  - Required: total 5 extra cycles.
- Conditional jumps, flag=4'b0100:
  - JMPN -> JMP1 with pc_write=1.
  - JMPZ -> F1 without pc_write.
  - JMPNZ taken; JMPNC taken.
  - JMPV not taken.
- CALL/RET, STACK_TOP=16'h00FF:
  - CALL -> sp_addr=16'h00FE on bus in CALL2; ram_write in CALL3; pc_write in CALL4.
  - RET -> sp_addr=16'h00FE in RET1; sp_addr=16'h00FF after RET2.
- Stack bounds, STACK_DEPTH=2:
  - Three nested CALLs -> third enters FAULT, fault=1, all strobes 0 and held.
  - After rst, a RET with depth 0 -> FAULT.
- Reset mid-operation: assert rst in CALL3 while mem_ready=0.
  - Required: next cycle IDLE, sp_addr=STACK_TOP, no ram_write pulse ever issued.

Source files
------------

// File: rtl/cu_stack_if.sv
// Control-unit boundary: IR/flag inputs and memory ready in, strobes, bus
// selects, stack address and status out.
interface cu_stack_if #(
  parameter int unsigned OPCODE_W = 8,
  parameter int unsigned ADDR_W   = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic [3:0]          flag;
  logic                mem_ready;
  logic [13:0]         cs;
  logic [5:0]          bus_cs;
  logic [ADDR_W-1:0]   sp_addr;
  logic                mem_req;
  logic                halted;
  logic                fault;

  modport master (
    input  opcode, flag, mem_ready,
    output cs, bus_cs, sp_addr, mem_req, halted, fault
  );

  modport slave (
    output opcode, flag, mem_ready,
    input  cs, bus_cs, sp_addr, mem_req, halted, fault
  );
endinterface

// File: rtl/cu_stack.sv
// SAP control unit: Moore FSM with memory wait states, conditional jumps on
// four flags, CALL/RET through a bounds-checked down-growing stack, sticky fault.
module cu_stack #(
  parameter int unsigned        OPCODE_W    = 8,
  parameter int unsigned        ADDR_W      = 16,
  parameter logic [ADDR_W-1:0]  STACK_TOP   = 16'hFFFF,
  parameter int unsigned        STACK_DEPTH = 16
) (
  input logic        clk,
  input logic        rst,
  cu_stack_if.master cu
);
  typedef enum logic [4:0] {
    IDLE, F1, F2, LDA1, LDA2, STA1, STA2, ALU1, ALU2, ALU3, JMP1, LDI1, OUT1,
    CALL1, CALL2, CALL3, CALL4, RET1, RET2, HLT, FAULT
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_LDA   = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_STA   = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_INCA  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_DECR  = OPCODE_W'(5);
  localparam logic [OPCODE_W-1:0] OP_JMPZ  = OPCODE_W'(6);
  localparam logic [OPCODE_W-1:0] OP_JMPC  = OPCODE_W'(7);
  localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(8);
  localparam logic [OPCODE_W-1:0] OP_LDI   = OPCODE_W'(10);
  localparam logic [OPCODE_W-1:0] OP_OUT   = OPCODE_W'(11);
  localparam logic [OPCODE_W-1:0] OP_HLT   = OPCODE_W'(12);
  localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(13);
  localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_XOR   = OPCODE_W'(15);
  localparam logic [OPCODE_W-1:0] OP_NOT   = OPCODE_W'(16);
  localparam logic [OPCODE_W-1:0] OP_JMPN  = OPCODE_W'(17);
  localparam logic [OPCODE_W-1:0] OP_JMPV  = OPCODE_W'(18);
  localparam logic [OPCODE_W-1:0] OP_JMPNZ = OPCODE_W'(19);
  localparam logic [OPCODE_W-1:0] OP_JMPNC = OPCODE_W'(20);
  localparam logic [OPCODE_W-1:0] OP_CALL  = OPCODE_W'(21);
  localparam logic [OPCODE_W-1:0] OP_RET   = OPCODE_W'(22);

  localparam logic [ADDR_W-1:0] DEPTH_MAX = ADDR_W'(STACK_DEPTH);

  state_t            state, nxt;
  logic [ADDR_W-1:0] sp, depth;
  logic              rdy;
  logic              acc_write, acc_lower_write, b_write, flag_write, ir_write;
  logic              mar_write, out_write, pc_inc, pc_write, ram_write;
  logic [3:0]        alu_op;
  logic              sp_to_bus, acc_to_bus, alu_to_bus, ir_to_bus, pc_to_bus, ram_to_bus;
  logic              mem_req;

  assign rdy = cu.mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sp    <= STACK_TOP;
      depth <= '0;
    end else begin
      state <= nxt;
      if (state == CALL1) begin
        sp    <= sp - 1'b1;
        depth <= depth + 1'b1;
      end else if (state == RET2 && rdy) begin
        sp    <= sp + 1'b1;
        depth <= depth - 1'b1;
      end
    end
  end

  always_comb begin
    nxt = state;
    {acc_write, acc_lower_write, b_write, flag_write, ir_write} = '0;
    {mar_write, out_write, pc_inc, pc_write, ram_write} = '0;
    alu_op = '0;
    {sp_to_bus, acc_to_bus, alu_to_bus, ir_to_bus, pc_to_bus, ram_to_bus} = '0;
    mem_req = 1'b0;
    unique case (state)
      IDLE: nxt = F1;
      F1: begin
        pc_to_bus = 1'b1;
        mar_write = 1'b1;
        nxt       = F2;
      end
      F2: begin
        mem_req    = 1'b1;
        ram_to_bus = 1'b1;
        ir_write   = rdy;
        pc_inc     = rdy;
        // Decode only on the completing cycle so waits simply stall in F2.
        if (rdy) begin
          case (cu.opcode)
            OP_LDA:                                 nxt = LDA1;
            OP_STA:                                 nxt = STA1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:  nxt = ALU1;
            OP_INCA, OP_DECR, OP_NOT:               nxt = ALU3;
            OP_JMP:                                 nxt = JMP1;
            OP_JMPZ:  nxt = cu.flag[0]  ? JMP1 : F1;
            OP_JMPC:  nxt = cu.flag[1]  ? JMP1 : F1;
            OP_JMPN:  nxt = cu.flag[2]  ? JMP1 : F1;
            OP_JMPV:  nxt = cu.flag[3]  ? JMP1 : F1;
            OP_JMPNZ: nxt = !cu.flag[0] ? JMP1 : F1;
            OP_JMPNC: nxt = !cu.flag[1] ? JMP1 : F1;
            OP_LDI:   nxt = LDI1;
            OP_OUT:   nxt = OUT1;
            OP_HLT:   nxt = HLT;
            OP_CALL:  nxt = (depth == DEPTH_MAX) ? FAULT : CALL1;
            OP_RET:   nxt = (depth == '0) ? FAULT : RET1;
            default:  nxt = F1;
          endcase
        end
      end
      LDA1, STA1, ALU1: begin
        ir_to_bus = 1'b1;
        mar_write = 1'b1;
        nxt = (state == LDA1) ? LDA2 : (state == STA1) ? STA2 : ALU2;
      end
      LDA2: begin
        mem_req    = 1'b1;
        ram_to_bus = 1'b1;
        acc_write  = rdy;
        if (rdy) nxt = F1;
      end
      STA2: begin
        mem_req    = 1'b1;
        acc_to_bus = 1'b1;
        ram_write  = rdy;
        if (rdy) nxt = F1;
      end
      ALU2: begin
        mem_req    = 1'b1;
        ram_to_bus = 1'b1;
        b_write    = rdy;
        if (rdy) nxt = ALU3;
      end
      ALU3: begin
        alu_to_bus = 1'b1;
        acc_write  = 1'b1;
        flag_write = 1'b1;
        case (cu.opcode)
          OP_SUB:  alu_op = 4'd1;
          OP_INCA: alu_op = 4'd2;
          OP_DECR: alu_op = 4'd3;
          OP_AND:  alu_op = 4'd4;
          OP_OR:   alu_op = 4'd5;
          OP_XOR:  alu_op = 4'd6;
          OP_NOT:  alu_op = 4'd7;
          default: alu_op = 4'd0;
        endcase
        nxt = F1;
      end
      JMP1, CALL4: begin
        ir_to_bus = 1'b1;
        pc_write  = 1'b1;
        nxt       = F1;
      end
      LDI1: begin
        ir_to_bus       = 1'b1;
        acc_lower_write = 1'b1;
        nxt             = F1;
      end
      OUT1: begin
        acc_to_bus = 1'b1;
        out_write  = 1'b1;
        nxt        = F1;
      end
      CALL1: nxt = CALL2;
      CALL2, RET1: begin
        sp_to_bus = 1'b1;
        mar_write = 1'b1;
        nxt       = (state == CALL2) ? CALL3 : RET2;
      end
      CALL3: begin
        mem_req   = 1'b1;
        pc_to_bus = 1'b1;
        ram_write = rdy;
        if (rdy) nxt = CALL4;
      end
      RET2: begin
        mem_req    = 1'b1;
        ram_to_bus = 1'b1;
        pc_write   = rdy;
        if (rdy) nxt = F1;
      end
      HLT:     nxt = HLT;
      FAULT:   nxt = FAULT;
      default: nxt = FAULT;
    endcase
  end

  assign cu.cs      = {acc_write, acc_lower_write, alu_op, b_write, flag_write,
                       ir_write, mar_write, out_write, pc_inc, pc_write, ram_write};
  assign cu.bus_cs  = {sp_to_bus, acc_to_bus, alu_to_bus, ir_to_bus, pc_to_bus, ram_to_bus};
  assign cu.sp_addr = sp;
  assign cu.mem_req = mem_req;
  assign cu.halted  = (state == HLT);
  assign cu.fault   = (state == FAULT);
endmodule

// File: tb/tb_cu_stack.sv
// Bench for cu_stack: per-instruction microstep tables with random wait states,
// stack/flag model tracked at the instruction level.
module tb_cu_stack;
  localparam logic [15:0] TOP   = 16'h00FF;
  localparam int          DEPTH = 2;

  localparam logic [13:0] C_ACCW = 14'h2000, C_ACCLW = 14'h1000, C_BW = 14'h0080,
                          C_FW = 14'h0040, C_IRW = 14'h0020, C_MARW = 14'h0010,
                          C_OUTW = 14'h0008, C_PCINC = 14'h0004, C_PCW = 14'h0002,
                          C_RAMW = 14'h0001;
  localparam logic [13:0] GATED = C_ACCW | C_BW | C_IRW | C_PCINC | C_PCW | C_RAMW;
  localparam logic [5:0]  B_SP = 6'b100000, B_ACC = 6'b010000, B_ALU = 6'b001000,
                          B_IR = 6'b000100, B_PC = 6'b000010, B_RAM = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_next = 1'b1;

  cu_stack_if #(.OPCODE_W(8), .ADDR_W(16)) cu_if ();

  cu_stack #(.OPCODE_W(8), .ADDR_W(16), .STACK_TOP(TOP), .STACK_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .cu (cu_if)
  );

  always #5 clk = ~clk;

  int nchk = 0, nfail = 0, ncyc = 0;
  int p_ir = 0, p_pcinc = 0, p_accw = 0, p_ramw = 0, p_pcw = 0;
  int m_sp = TOP, m_depth = 0;
  bit m_halt = 0, m_fault = 0, no_waits = 0;
  int forced[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_pulses();
    p_ir = 0; p_pcinc = 0; p_accw = 0; p_ramw = 0; p_pcw = 0;
  endtask

  // One clock cycle: drive at negedge, sample just after, before the next posedge.
  task automatic cyc(input logic [7:0] op, input logic [3:0] fl, input logic rdy,
                     input logic [13:0] ecs, input logic [5:0] ebus, input logic emreq,
                     input string tag);
    @(negedge clk);
    rst = rst_next;
    cu_if.opcode = op;
    cu_if.flag = fl;
    cu_if.mem_ready = rdy;
    #1;
    check_eq({tag, ".cs"}, 32'(cu_if.cs), 32'(ecs));
    check_eq({tag, ".bus"}, 32'(cu_if.bus_cs), 32'(ebus));
    check_eq({tag, ".mreq"}, 32'(cu_if.mem_req), 32'(emreq));
    check_eq({tag, ".halted"}, 32'(cu_if.halted), 32'(m_halt));
    check_eq({tag, ".fault"}, 32'(cu_if.fault), 32'(m_fault));
    check_eq({tag, ".sp"}, 32'(cu_if.sp_addr), 32'(m_sp));
    if (cu_if.cs[5]) p_ir++;
    if (cu_if.cs[2]) p_pcinc++;
    if (cu_if.cs[13]) p_accw++;
    if (cu_if.cs[0]) p_ramw++;
    if (cu_if.cs[1]) p_pcw++;
    ncyc++;
  endtask

  task automatic step(input logic [7:0] op, input logic [3:0] fl, input logic [13:0] ecs,
                      input logic [5:0] ebus, input bit mem, input string tag);
    int nw;
    if (mem) begin
      if (forced.size() > 0) nw = forced.pop_front();
      else if (no_waits) nw = 0;
      else nw = $urandom_range(0, 2);
      repeat (nw) cyc(op, fl, 1'b0, ecs & ~GATED, ebus, 1'b1, {tag, "_wait"});
      cyc(op, fl, 1'b1, ecs, ebus, 1'b1, tag);
    end else begin
      cyc(op, fl, 1'($urandom_range(0, 1)), ecs, ebus, 1'b0, tag);
    end
  endtask

  function automatic logic [13:0] alu_cs(input int op);
    int code;
    case (op)
      2: code = 0;  3: code = 1;  4: code = 2;  5: code = 3;
      13: code = 4; 14: code = 5; 15: code = 6; 16: code = 7;
      default: code = 0;
    endcase
    return C_ACCW | C_FW | 14'(code << 8);
  endfunction

  // Whole instruction from F1 onwards; leaves the model at F1, HLT or FAULT.
  task automatic exec_instr(input int op, input logic [3:0] fl);
    logic [7:0] o;
    bit taken;
    o = 8'(op);
    step(o, fl, C_MARW, B_PC, 0, "f1");
    step(o, fl, C_IRW | C_PCINC, B_RAM, 1, "f2");
    case (op)
      0: begin
        step(o, fl, C_MARW, B_IR, 0, "lda1");
        step(o, fl, C_ACCW, B_RAM, 1, "lda2");
      end
      1: begin
        step(o, fl, C_MARW, B_IR, 0, "sta1");
        step(o, fl, C_RAMW, B_ACC, 1, "sta2");
      end
      2, 3, 13, 14, 15: begin
        step(o, fl, C_MARW, B_IR, 0, "alu1");
        step(o, fl, C_BW, B_RAM, 1, "alu2");
        step(o, fl, alu_cs(op), B_ALU, 0, "alu3");
      end
      4, 5, 16: step(o, fl, alu_cs(op), B_ALU, 0, "alu3u");
      6, 7, 8, 17, 18, 19, 20: begin
        case (op)
          6: taken = fl[0];   7: taken = fl[1];   17: taken = fl[2];
          18: taken = fl[3];  19: taken = !fl[0]; 20: taken = !fl[1];
          default: taken = 1;
        endcase
        if (taken) step(o, fl, C_PCW, B_IR, 0, "jmp1");
      end
      10: step(o, fl, C_ACCLW, B_IR, 0, "ldi1");
      11: step(o, fl, C_OUTW, B_ACC, 0, "out1");
      12: m_halt = 1;
      21: begin
        if (m_depth == DEPTH) m_fault = 1;
        else begin
          step(o, fl, '0, '0, 0, "call1");
          m_sp = (m_sp - 1) & 16'hFFFF;
          m_depth++;
          step(o, fl, C_MARW, B_SP, 0, "call2");
          step(o, fl, C_RAMW, B_PC, 1, "call3");
          step(o, fl, C_PCW, B_IR, 0, "call4");
        end
      end
      22: begin
        if (m_depth == 0) m_fault = 1;
        else begin
          step(o, fl, C_MARW, B_SP, 0, "ret1");
          step(o, fl, C_PCW, B_RAM, 1, "ret2");
          m_sp = (m_sp + 1) & 16'hFFFF;
          m_depth--;
        end
      end
      default: ;
    endcase
  endtask

  task automatic absorb(input int n, input string tag);
    repeat (n) cyc(8'($urandom_range(0, 31)), 4'($urandom), 1'($urandom_range(0, 1)),
                   '0, '0, 1'b0, tag);
  endtask

  int idle_start;

  task automatic do_reset(input int n);
    rst_next = 1;
    @(negedge clk);
    rst = 1'b1;
    m_sp = TOP; m_depth = 0; m_halt = 0; m_fault = 0;
    repeat (n - 1) cyc(8'd0, 4'd0, 1'b1, '0, '0, 1'b0, "rst");
    rst_next = 0;
    idle_start = ncyc;
    cyc(8'd0, 4'd0, 1'b1, '0, '0, 1'b0, "idle");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cu_if.opcode = '0;
    cu_if.flag = '0;
    cu_if.mem_ready = 1'b1;

    // Reset, then LDA, ADD, OUT, HLT with no wait states.
    do_reset(3);
    no_waits = 1;
    exec_instr(0, 4'h0);
    exec_instr(2, 4'h0);
    exec_instr(11, 4'h0);
    exec_instr(12, 4'h0);
    absorb(1, "hlt");
    check_eq("halt_cycle", 32'(ncyc - idle_start), 32'd16);
    absorb(3, "hlt_hold");
    no_waits = 0;

    // LDA with 3 waits in F2 and 2 in LDA2.
    do_reset(2);
    clr_pulses();
    idle_start = ncyc;
    forced.push_back(3);
    forced.push_back(2);
    exec_instr(0, 4'h0);
    check_eq("wait_ir_pulses", 32'(p_ir), 32'd1);
    check_eq("wait_pcinc_pulses", 32'(p_pcinc), 32'd1);
    check_eq("wait_accw_pulses", 32'(p_accw), 32'd1);
    check_eq("wait_cycles", 32'(ncyc - idle_start), 32'd9);

    // Conditional jumps with only N set.
    clr_pulses(); exec_instr(17, 4'b0100); check_eq("jmpn_taken", 32'(p_pcw), 32'd1);
    clr_pulses(); exec_instr(6, 4'b0100);  check_eq("jmpz_not_taken", 32'(p_pcw), 32'd0);
    clr_pulses(); exec_instr(19, 4'b0100); check_eq("jmpnz_taken", 32'(p_pcw), 32'd1);
    clr_pulses(); exec_instr(20, 4'b0100); check_eq("jmpnc_taken", 32'(p_pcw), 32'd1);
    clr_pulses(); exec_instr(18, 4'b0100); check_eq("jmpv_not_taken", 32'(p_pcw), 32'd0);

    // CALL then RET: SP moves FF -> FE -> FF.
    clr_pulses();
    exec_instr(21, 4'h0);
    check_eq("call_ramw", 32'(p_ramw), 32'd1);
    check_eq("call_sp", 32'(cu_if.sp_addr), 32'h00FE);
    exec_instr(22, 4'h0);
    exec_instr(9, 4'h0);
    check_eq("ret_sp", 32'(cu_if.sp_addr), 32'h00FF);

    // Stack overflow on the third nested CALL, then underflow after reset.
    do_reset(2);
    exec_instr(21, 4'h0);
    exec_instr(21, 4'h0);
    exec_instr(21, 4'h0);
    absorb(4, "ovf_hold");
    check_eq("ovf_fault", 32'(cu_if.fault), 32'd1);
    do_reset(2);
    exec_instr(22, 4'h0);
    absorb(3, "unf_hold");

    // Reset while CALL3 is waiting on memory.
    do_reset(2);
    clr_pulses();
    step(8'd21, 4'h0, C_MARW, B_PC, 0, "f1");
    step(8'd21, 4'h0, C_IRW | C_PCINC, B_RAM, 1, "f2");
    step(8'd21, 4'h0, '0, '0, 0, "call1");
    m_sp = TOP - 1; m_depth = 1;
    step(8'd21, 4'h0, C_MARW, B_SP, 0, "call2");
    rst_next = 1;
    cyc(8'd21, 4'h0, 1'b0, '0, B_PC, 1'b1, "call3_rst");
    rst_next = 0;
    m_sp = TOP; m_depth = 0;
    cyc(8'd21, 4'h0, 1'b1, '0, '0, 1'b0, "idle_after_rst");
    check_eq("rst_no_ramw", 32'(p_ramw), 32'd0);
    check_eq("rst_sp_top", 32'(cu_if.sp_addr), 32'(TOP));

    // Random instruction stream with random flags and wait states.
    for (int i = 0; i < 300; i++) begin
      int op;
      op = $urandom_range(0, 31);
      if (op == 12 && $urandom_range(0, 3) != 0) op = 9;
      exec_instr(op, 4'($urandom));
      if (m_halt || m_fault) begin
        absorb(3, "rand_hold");
        do_reset(2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
